// File: rtl/bm_pkg.sv
// Shared types and helpers for the block-matching pipeline
// (hamming_dist_scanner -> min_dist_finder).
package bm_pkg;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] x;
    } coord_t;

    typedef enum logic {
        IDLE,
        SCAN
    } scan_state_t;

    function automatic logic [7:0] sat_popcount(input int unsigned count);
        return (count > 255) ? 8'hFF : 8'(count);
    endfunction

    // The scan ends on the bottom row with x counted down to zero; a window
    // with no candidates in either dimension collapses to the origin.
    function automatic coord_t coord_last(input int unsigned ny, input int unsigned nx);
        coord_t c;
        c = '0;
        if (ny != 0 && nx != 0)
            c.y = 8'(ny - 1);
        return c;
    endfunction

endpackage

// File: rtl/hamming_dist_scanner_if.sv
// Load-side and result-side signals of hamming_dist_scanner, grouped for
// hookup to the upstream loader and the downstream min_dist_finder.
interface hamming_dist_scanner_if #(
    parameter int blk_size  = 256,
    parameter int srch_size = 1280
);
    logic [blk_size-1:0]  ref_blk;
    logic [srch_size-1:0] srch_blk;
    logic [15:0]          blk_index_i;
    logic                 in_valid;
    logic                 in_ready;
    logic [blk_size-1:0]  xors;
    logic [7:0]           sum;
    logic [15:0]          out_coords;
    logic [15:0]          blk_index_o;
    logic                 sum_valid;
    logic                 busy;

    modport master (
        output ref_blk, srch_blk, blk_index_i, in_valid,
        input  in_ready, xors, sum, out_coords, blk_index_o, sum_valid, busy
    );

    modport slave (
        input  ref_blk, srch_blk, blk_index_i, in_valid,
        output in_ready, xors, sum, out_coords, blk_index_o, sum_valid, busy
    );
endinterface

// File: rtl/census_window_extract.sv
// Combinational blk_h x blk_w sub-window of the search census at (y, x),
// XORed with the reference census.
module census_window_extract
    import bm_pkg::*;
#(
    parameter int blk_h        = 16,
    parameter int blk_w        = 16,
    parameter int search_blk_h = 20,
    parameter int search_blk_w = 64,
    parameter int blk_size     = blk_h * blk_w,
    parameter int srch_size    = search_blk_h * search_blk_w
) (
    input  logic [blk_size-1:0]  ref_blk,
    input  logic [srch_size-1:0] srch_blk,
    input  coord_t               pos,
    output logic [blk_size-1:0]  xors
);

    // One shifter per row keeps every selected bit in use and the row
    // width exact, instead of a single full-window shift.
    for (genvar r = 0; r < blk_h; r++) begin : g_row
        logic [31:0]      row_off;
        logic [blk_w-1:0] row_bits;

        assign row_off  = (32'(r) + 32'(pos.y)) * 32'(search_blk_w) + 32'(pos.x);
        assign row_bits = blk_w'(srch_blk >> row_off);
        assign xors[r*blk_w +: blk_w] = ref_blk[r*blk_w +: blk_w] ^ row_bits;
    end

endmodule

// File: rtl/hamming_dist_scanner.sv
// Walks every candidate offset of a census search window, one per clock,
// emitting XOR map, saturated Hamming sum, offset and block index.
module hamming_dist_scanner
    import bm_pkg::*;
#(
    parameter int blk_h        = 16,
    parameter int blk_w        = 16,
    parameter int search_blk_h = 20,
    parameter int search_blk_w = 64,
    parameter int blk_size     = blk_h * blk_w,
    parameter int srch_size    = search_blk_h * search_blk_w
) (
    input logic                 clk,
    input logic                 reset,
    hamming_dist_scanner_if.slave bus
);

    localparam int unsigned NY      = search_blk_h - blk_h;
    localparam int unsigned NX      = search_blk_w - blk_w;
    localparam int unsigned CNT_W   = $clog2(blk_size) + 1;
    localparam coord_t      LAST    = coord_last(NY, NX);
    localparam logic [7:0]  X_START = 8'(NX - 1);

    logic [blk_size-1:0]  shadow_ref, act_ref;
    logic [srch_size-1:0] shadow_srch, act_srch;
    logic [15:0]          shadow_index, act_index;
    logic                 shadow_full;

    scan_state_t state, state_next;
    coord_t      cur, cur_next;
    logic        load, issue, last_issue, swap;

    logic [blk_size-1:0] win_xors;
    logic [blk_size-1:0] s1_xors, s2_xors;
    coord_t              s1_coords, s2_coords;
    logic [15:0]         s1_index, s2_index;
    logic                s1_valid, s2_valid;
    logic [7:0]          s2_sum;
    logic [CNT_W-1:0]    pop;

    assign load       = bus.in_valid && !shadow_full;
    assign issue      = (state == SCAN);
    assign last_issue = issue && (cur == LAST);

    always_comb begin
        state_next = state;
        swap       = 1'b0;
        cur_next   = cur;
        case (state)
            IDLE: begin
                if (shadow_full) begin
                    swap       = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (last_issue) begin
                    if (shadow_full)
                        swap = 1'b1;
                    else
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (swap) begin
            cur_next.y = '0;
            cur_next.x = X_START;
        end else if (issue) begin
            if (cur.x == '0) begin
                cur_next.y = cur.y + 8'd1;
                cur_next.x = X_START;
            end else begin
                cur_next.x = cur.x - 8'd1;
            end
        end
    end

    // A load only happens with the shadow empty and a swap only with it full,
    // so both in one cycle means the swap takes the old contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cur          <= '0;
            shadow_full  <= 1'b0;
            shadow_ref   <= '0;
            shadow_srch  <= '0;
            shadow_index <= '0;
            act_ref      <= '0;
            act_srch     <= '0;
            act_index    <= '0;
        end else begin
            state       <= state_next;
            cur         <= cur_next;
            shadow_full <= load || (shadow_full && !swap);
            if (load) begin
                shadow_ref   <= bus.ref_blk;
                shadow_srch  <= bus.srch_blk;
                shadow_index <= bus.blk_index_i;
            end
            if (swap) begin
                act_ref   <= shadow_ref;
                act_srch  <= shadow_srch;
                act_index <= shadow_index;
            end
        end
    end

    census_window_extract #(
        .blk_h        (blk_h),
        .blk_w        (blk_w),
        .search_blk_h (search_blk_h),
        .search_blk_w (search_blk_w),
        .blk_size     (blk_size),
        .srch_size    (srch_size)
    ) u_extract (
        .ref_blk  (act_ref),
        .srch_blk (act_srch),
        .pos      (cur),
        .xors     (win_xors)
    );

    assign pop = CNT_W'($countones(s1_xors));

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_xors   <= '0;
            s1_coords <= '0;
            s1_index  <= '0;
            s2_valid  <= 1'b0;
            s2_xors   <= '0;
            s2_coords <= '0;
            s2_index  <= '0;
            s2_sum    <= '0;
        end else begin
            s1_valid <= issue;
            if (issue) begin
                s1_xors   <= win_xors;
                s1_coords <= cur;
                s1_index  <= act_index;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_xors   <= s1_xors;
                s2_coords <= s1_coords;
                s2_index  <= s1_index;
                s2_sum    <= sat_popcount(32'(pop));
            end
        end
    end

    assign bus.in_ready    = !shadow_full;
    assign bus.xors        = s2_xors;
    assign bus.sum         = s2_sum;
    assign bus.out_coords  = s2_coords;
    assign bus.blk_index_o = s2_index;
    assign bus.sum_valid   = s2_valid;
    assign bus.busy        = issue || s1_valid || s2_valid;

endmodule

// File: tb/tb_hamming_dist_scanner.sv
// Directed bench for hamming_dist_scanner: a 4x4-in-6x8 instance for ordering,
// handshake and reset cases, and a default-size instance for saturation.
module tb_hamming_dist_scanner;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    hamming_dist_scanner_if #(.blk_size(16),  .srch_size(48))   s_if();
    hamming_dist_scanner_if #(.blk_size(256), .srch_size(1280)) d_if();

    hamming_dist_scanner #(
        .blk_h(4), .blk_w(4), .search_blk_h(6), .search_blk_w(8),
        .blk_size(16), .srch_size(48)
    ) u_small (
        .clk   (clk),
        .reset (reset),
        .bus   (s_if.slave)
    );

    hamming_dist_scanner u_dflt (
        .clk   (clk),
        .reset (reset),
        .bus   (d_if.slave)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Small-instance patterns: 0 all zero, 1 single srch bit at row 1 col 3,
    // 2 srch row 0 all ones, 3 ref all ones.
    function automatic logic [15:0] pat_ref(input int pat);
        return (pat == 3) ? 16'hFFFF : 16'h0000;
    endfunction

    function automatic logic [47:0] pat_srch(input int pat);
        case (pat)
            1:       return 48'h0000_0000_0800;
            2:       return 48'h0000_0000_00FF;
            default: return 48'h0;
        endcase
    endfunction

    function automatic logic [15:0] exp_xors(input int pat, input int k);
        int y, x;
        logic [15:0] one;
        y   = k / 4;
        x   = 3 - (k % 4);
        one = 16'h0001;
        case (pat)
            1:       return one << ((1 - y) * 4 + (3 - x));
            2:       return (y == 0) ? 16'h000F : 16'h0000;
            3:       return 16'hFFFF;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [7:0] exp_sum(input int pat, input int k);
        case (pat)
            1:       return 8'd1;
            2:       return (k < 4) ? 8'd4 : 8'd0;
            3:       return 8'd16;
            default: return 8'd0;
        endcase
    endfunction

    task automatic start_load(input int pat, input logic [15:0] idx);
        s_if.ref_blk     = pat_ref(pat);
        s_if.srch_blk    = pat_srch(pat);
        s_if.blk_index_i = idx;
        s_if.in_valid    = 1'b1;
    endtask

    task automatic check_beat(input string blk, input int pat, input int k, input logic [15:0] idx);
        logic [15:0] coords;
        coords = {8'(k / 4), 8'(3 - (k % 4))};
        check($sformatf("%s_b%0d_valid", blk, k),  256'(s_if.sum_valid),   256'(1'b1));
        check($sformatf("%s_b%0d_coords", blk, k), 256'(s_if.out_coords),  256'(coords));
        check($sformatf("%s_b%0d_xors", blk, k),   256'(s_if.xors),        256'(exp_xors(pat, k)));
        check($sformatf("%s_b%0d_sum", blk, k),    256'(s_if.sum),         256'(exp_sum(pat, k)));
        check($sformatf("%s_b%0d_index", blk, k),  256'(s_if.blk_index_o), 256'(idx));
    endtask

    task automatic wait_beat(input bit dflt, output int n);
        n = 0;
        while (!(dflt ? d_if.sum_valid : s_if.sum_valid) && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int seen;

        reset            = 1'b1;
        s_if.in_valid    = 1'b0;
        s_if.ref_blk     = '0;
        s_if.srch_blk    = '0;
        s_if.blk_index_i = '0;
        d_if.in_valid    = 1'b0;
        d_if.ref_blk     = '0;
        d_if.srch_blk    = '0;
        d_if.blk_index_i = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_valid",  256'(s_if.sum_valid),   256'(1'b0));
        check("rst_ready",  256'(s_if.in_ready),    256'(1'b1));
        check("rst_busy",   256'(s_if.busy),        256'(1'b0));
        check("rst_sum",    256'(s_if.sum),         256'(8'd0));
        check("rst_coords", 256'(s_if.out_coords),  256'(16'd0));
        check("rst_index",  256'(s_if.blk_index_o), 256'(16'd0));
        check("rst_xors",   256'(s_if.xors),        256'(16'd0));
        check("rst_d_ready", 256'(d_if.in_ready),   256'(1'b1));
        check("rst_d_valid", 256'(d_if.sum_valid),  256'(1'b0));

        // Single block, all zero
        start_load(0, 16'h0005);
        check("t1_ready_in", 256'(s_if.in_ready), 256'(1'b1));
        @(negedge clk);
        s_if.in_valid = 1'b0;
        check("t1_ready_full", 256'(s_if.in_ready), 256'(1'b0));
        wait_beat(1'b0, n);
        check("t1_latency", 256'(n), 256'(3));
        for (int k = 0; k < 8; k++) begin
            check_beat("t1", 0, k, 16'h0005);
            @(negedge clk);
        end
        check("t1_end_valid", 256'(s_if.sum_valid), 256'(1'b0));
        check("t1_end_busy",  256'(s_if.busy),      256'(1'b0));

        // Single set search bit, one XOR bit per candidate
        start_load(1, 16'h1234);
        @(negedge clk);
        s_if.in_valid = 1'b0;
        wait_beat(1'b0, n);
        check("t2_latency", 256'(n), 256'(3));
        for (int k = 0; k < 8; k++) begin
            check_beat("t2", 1, k, 16'h1234);
            @(negedge clk);
        end
        check("t2_end_valid", 256'(s_if.sum_valid), 256'(1'b0));

        // Back-to-back loads, second in_valid held until accepted
        start_load(2, 16'h00A1);
        @(negedge clk);
        check("t3_ready_full", 256'(s_if.in_ready), 256'(1'b0));
        start_load(3, 16'h00B2);
        @(negedge clk);
        check("t3_ready_free", 256'(s_if.in_ready), 256'(1'b1));
        @(negedge clk);
        s_if.in_valid = 1'b0;
        check("t3_ready_drop", 256'(s_if.in_ready), 256'(1'b0));
        wait_beat(1'b0, n);
        check("t3_latency", 256'(n), 256'(1));
        for (int k = 0; k < 16; k++) begin
            if (k < 8)
                check_beat("t3a", 2, k, 16'h00A1);
            else
                check_beat("t3b", 3, k - 8, 16'h00B2);
            @(negedge clk);
        end
        check("t3_end_valid", 256'(s_if.sum_valid), 256'(1'b0));
        check("t3_end_busy",  256'(s_if.busy),      256'(1'b0));

        // Reset on beat 4 with the shadow holding a second block
        start_load(1, 16'h0C01);
        @(negedge clk);
        start_load(0, 16'h0C02);
        @(negedge clk);
        @(negedge clk);
        s_if.in_valid = 1'b0;
        wait_beat(1'b0, n);
        check("t4_latency", 256'(n), 256'(1));
        for (int k = 0; k < 4; k++) begin
            check_beat("t4", 1, k, 16'h0C01);
            if (k < 3)
                @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t4_rst_valid",  256'(s_if.sum_valid),   256'(1'b0));
        check("t4_rst_ready",  256'(s_if.in_ready),    256'(1'b1));
        check("t4_rst_busy",   256'(s_if.busy),        256'(1'b0));
        check("t4_rst_coords", 256'(s_if.out_coords),  256'(16'd0));
        check("t4_rst_index",  256'(s_if.blk_index_o), 256'(16'd0));
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (s_if.sum_valid)
                seen++;
        end
        check("t4_no_beats",  256'(seen),           256'(0));
        check("t4_ready_end", 256'(s_if.in_ready),  256'(1'b1));

        // Load lands on the final issue with the shadow empty
        start_load(3, 16'h00D1);
        @(negedge clk);
        s_if.in_valid = 1'b0;
        wait_beat(1'b0, n);
        check("t5_latency", 256'(n), 256'(3));
        for (int k = 0; k < 8; k++) begin
            check_beat("t5a", 3, k, 16'h00D1);
            if (k == 5) begin
                check("t5_ready_in", 256'(s_if.in_ready), 256'(1'b1));
                start_load(2, 16'h00D2);
            end
            if (k == 6) begin
                s_if.in_valid = 1'b0;
                check("t5_ready_full", 256'(s_if.in_ready), 256'(1'b0));
            end
            @(negedge clk);
        end
        check("t5_gap_valid", 256'(s_if.sum_valid), 256'(1'b0));
        check("t5_gap_busy",  256'(s_if.busy),      256'(1'b1));
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            check_beat("t5b", 2, k, 16'h00D2);
            @(negedge clk);
        end
        check("t5_end_valid", 256'(s_if.sum_valid), 256'(1'b0));

        // Default geometry: 256 mismatches saturate to 255 on all 192 candidates
        d_if.ref_blk     = '1;
        d_if.srch_blk    = '0;
        d_if.blk_index_i = 16'h0777;
        d_if.in_valid    = 1'b1;
        @(negedge clk);
        d_if.in_valid = 1'b0;
        wait_beat(1'b1, n);
        check("t6_latency", 256'(n), 256'(3));
        check("t6_xors", d_if.xors, {256{1'b1}});
        for (int k = 0; k < 192; k++) begin
            check($sformatf("t6_b%0d_valid", k),  256'(d_if.sum_valid),  256'(1'b1));
            check($sformatf("t6_b%0d_sum", k),    256'(d_if.sum),        256'(8'hFF));
            check($sformatf("t6_b%0d_coords", k), 256'(d_if.out_coords),
                  256'({8'(k / 48), 8'(47 - (k % 48))}));
            if (k == 191) begin
                check("t6_last_coords", 256'(d_if.out_coords),  256'(16'h0300));
                check("t6_last_index",  256'(d_if.blk_index_o), 256'(16'h0777));
            end
            @(negedge clk);
        end
        check("t6_end_valid", 256'(d_if.sum_valid), 256'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hamming_dist_scanner.md
Name: hamming_dist_scanner

Overview:
- Upstream feeder of min_dist_finder in the block-matching pipeline.
- Accepts one reference census block and its census search window per handshake.
- Walks every candidate offset, one per clock, and emits per candidate: XOR map, saturated Hamming sum, offset coordinates and block index.
- Output ports connect 1:1 to min_dist_finder inputs (xors, sum, out_coords, blk_index_o, sum_valid).

Parameters:
- blk_h, 16, reference block height in pixels (1 census bit per pixel)
- blk_w, 16, reference block width
- search_blk_h, 20, search window height; must be > blk_h
- search_blk_w, 64, search window width; must be > blk_w
- blk_size, blk_h*blk_w, XOR map width
- srch_size, search_blk_h*search_blk_w, search window width in bits
- Defaults must equal those of the downstream min_dist_finder instance.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ref_blk  in  blk_size  reference census bits; bit r*blk_w+c is row r, column c
- srch_blk  in  srch_size  search census bits; bit r*search_blk_w+c is row r, column c
- blk_index_i  in  16  block index, passed through unchanged
- in_valid  in  1  load request
- in_ready  out  1  shadow buffer empty; load accepted when in_valid && in_ready
- xors  out  blk_size  XOR map of current candidate
- sum  out  8  saturated popcount of xors
- out_coords  out  16  [15:8] = vertical offset y, [7:0] = horizontal offset x
- blk_index_o  out  16  index of the block being scanned
- sum_valid  out  1  output qualifier; no backpressure (downstream always accepts)
- busy  out  1  scan active or pipeline non-empty

Behaviour:
- Constants: NY = search_blk_h-blk_h; NX = search_blk_w-blk_w; num_sums = NY*NX.
- Two window buffers: shadow (load side) and active (scan side), each holding ref, srch and index.
- in_ready = !shadow_full.
- A handshake writes shadow and sets shadow_full.
- Scan FSM states: IDLE, SCAN.
  - IDLE: if shadow_full, copy shadow to active, clear shadow_full, enter SCAN with y=0, x=NX-1.
  - SCAN: issue one candidate per cycle.
  - Order: y outer ascending 0..NY-1; x inner descending NX-1..0.
  - Final candidate is (y=NY-1, x=0); this matches the downstream end-of-block detect.
  - On issuing the final candidate: if shadow_full, swap immediately and restart at (0, NX-1) next cycle with no bubble; otherwise go to IDLE.
- Simultaneous handshake and swap in the same cycle: the swap reads the old shadow contents, and the new load lands in shadow. in_ready is low that cycle unless the shadow was empty, so no overwrite is possible.
- Pipeline, fixed latency 2 from issue to sum_valid:
  - Stage 1 registers xors[r*blk_w+c] = ref[r*blk_w+c] ^ srch[(r+y)*search_blk_w + c+x], plus coords and index.
  - Stage 2 registers sum = min(popcount(xors), 255), and delays xors, coords, index and valid to align.
- Arithmetic:
  - popcount is computed at $clog2(blk_size)+1 bits, then saturated to 8'hFF.
  - Coordinates are zero-extended to 8 bits per field.
- sum_valid is high for exactly num_sums consecutive cycles per block when scans are back-to-back. Gaps appear only between blocks.
- Reset: all outputs 0, sum_valid 0, in_ready 1, busy 0, FSM IDLE, shadow empty.
- Reset mid-scan aborts the scan: in-flight pipeline entries are dropped, the shadow is discarded, and no partial outputs appear afterwards.
- busy = (state==SCAN) || any pipeline stage valid.

Decomposition:
- Shared package bm_pkg:
  - typedef coord_t (packed struct {y[7:0], x[7:0]})
  - function sat_popcount
  - constant COORD_LAST helper function (NY, NX)
- One sub-module, census_window_extract: combinational blk_h x blk_w sub-window selection of srch at (y, x), XORed with ref. Instantiated once in stage 1.

Test Plan (blk 4x4, search 6x8 unless noted, so NY=2, NX=4, num_sums=8):
- Single block, ref all 0, srch all 0, index 16'h0005 -> 8 sum_valid beats; coords 0x0003,0x0002,0x0001,0x0000,0x0103,...,0x0100; all sums 0; blk_index_o 0x0005; first beat 2 cycles after first issue.
- srch has a single 1 at row 1, column 3, ref all 0 -> sum 1 only at coords where 0<=1-y<4 and 0<=3-x<4, i.e. all 8 candidates give sum 1 with exactly one xors bit set at (1-y)*4+(3-x); verify bit positions.
- Back-to-back loads, second in_valid held -> in_ready drops after second accept; the 16 output beats are contiguous with no gap; blk_index_o switches on beat 9.
- Default params, ref all 1, srch all 0 -> popcount 256 saturates to sum 8'hFF for all 192 candidates; last coords 0x0300.
- Reset asserted at beat 4 of a scan with shadow full -> sum_valid 0 from the next cycle on; in_ready 1; no further beats until a new load.
- Load handshake on the same cycle as the final issue with the shadow empty -> next scan starts 2 cycles later (IDLE then SCAN); ordering and indices preserved.
